// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N:1 stream multiplexer.
package mux_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester after ptr wins, wrapping to 0.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int SEL_W  = clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [SEL_W-1:0]  gnt_idx
);

  always_comb begin
    logic found;
    int   j;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    j       = 0;
    // k = NUM_CH revisits ptr itself, so the last winner can win again when alone
    for (int k = 1; k <= NUM_CH; k++) begin
      j = (int'(ptr) + k) % NUM_CH;
      if (!found && req[j]) begin
        gnt[j]  = 1'b1;
        gnt_idx = SEL_W'(j);
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_nx1_stream.sv
// N-channel registered stream mux with explicit-select or round-robin grant.
// Optional per-channel accepted-beat counters when MUX_STATS_EN is defined.
module mux_nx1_stream
  import mux_pkg::*;
#(
  parameter int W      = 8,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = clog2(NUM_CH),
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH*W-1:0]     in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  output logic [W-1:0]            out_data,
  output logic [SEL_W-1:0]        out_ch,
  output logic                    out_valid,
  input  logic                    out_ready
`ifdef MUX_STATS_EN
  ,
  output logic [NUM_CH*CNT_W-1:0] stat_cnt
`endif
);

  typedef struct packed {
    logic [W-1:0]     data;
    logic [SEL_W-1:0] ch;
  } beat_t;

  if (NUM_CH < 2 || CNT_W < 1) begin : g_bad_cfg
  end

  logic [SEL_W-1:0]  rr_ptr;
  logic [NUM_CH-1:0] arb_gnt, sel_gnt, grant, xfer_ch;
  logic [SEL_W-1:0]  arb_idx, gnt_idx;
  logic              slot_free, xfer;
  beat_t             beat_q, beat_d;

  rr_arbiter #(.NUM_CH(NUM_CH), .SEL_W(SEL_W)) u_arb (
    .req     (in_valid),
    .ptr     (rr_ptr),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  // Out-of-range sel matches no lane, so it grants nothing
  always_comb begin
    sel_gnt = '0;
    for (int i = 0; i < NUM_CH; i++)
      sel_gnt[i] = (sel == SEL_W'(i)) & in_valid[i];
  end

  assign grant     = (mode == MODE_RR) ? arb_gnt : sel_gnt;
  assign gnt_idx   = (mode == MODE_RR) ? arb_idx : sel;
  assign slot_free = !out_valid | out_ready;
  assign in_ready  = grant & {NUM_CH{slot_free & rst_n}};
  assign xfer_ch   = in_valid & in_ready;
  assign xfer      = |xfer_ch;

  always_comb begin
    beat_d.data = '0;
    beat_d.ch   = gnt_idx;
    for (int i = 0; i < NUM_CH; i++)
      if (grant[i]) beat_d.data = in_data[i*W +: W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q    <= '0;
      out_valid <= 1'b0;
      rr_ptr    <= SEL_W'(NUM_CH - 1);
    end else begin
      if (xfer) begin
        beat_q    <= beat_d;
        out_valid <= 1'b1;
        if (mode == MODE_RR) rr_ptr <= arb_idx;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign out_data = beat_q.data;
  assign out_ch   = beat_q.ch;

`ifdef MUX_STATS_EN
  for (genvar i = 0; i < NUM_CH; i++) begin : g_stat
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                      cnt <= '0;
      else if (xfer_ch[i] && cnt != '1) cnt <= cnt + 1'b1;
    end
    assign stat_cnt[i*CNT_W +: CNT_W] = cnt;
  end
`endif

endmodule

// File: tb/tb_mux_nx1_stream.sv
// Directed bench for mux_nx1_stream; stats checks run when MUX_STATS_EN is defined.
module tb_mux_nx1_stream;

  localparam int W      = 8;
  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;
`ifdef MUX_STATS_EN
  localparam int CNT_W  = 4;
`else
  localparam int CNT_W  = 16;
`endif

  logic                clk, rst_n;
  logic [NUM_CH*W-1:0] in_data;
  logic [NUM_CH-1:0]   in_valid, in_ready;
  logic                mode;
  logic [SEL_W-1:0]    sel;
  logic [W-1:0]        out_data;
  logic [SEL_W-1:0]    out_ch;
  logic                out_valid, out_ready;
`ifdef MUX_STATS_EN
  logic [NUM_CH*CNT_W-1:0] stat_cnt;
`endif

  int total = 0;
  int bad   = 0;

  mux_nx1_stream #(.W(W), .NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef MUX_STATS_EN
    ,
    .stat_cnt  (stat_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_data   = {8'h13, 8'h12, 8'h11, 8'h10};
    in_valid  = 4'b1111;
    mode      = 1'b1;
    sel       = 2'd0;
    out_ready = 1'b1;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_out_ch",    32'(out_ch),    32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd0);
`ifdef MUX_STATS_EN
    chk("rst_stat", 32'(stat_cnt), 32'd0);
`endif
    in_valid = 4'b0000;
    do_reset();

    // explicit select
    mode     = 1'b0;
    sel      = 2'd2;
    in_valid = 4'b0100;
    in_data  = {8'h00, 8'hA5, 8'h00, 8'h00};
    #1;
    chk("sel_in_ready", 32'(in_ready), 32'b0100);
    step();
    chk("sel_out_data",  32'(out_data),  32'hA5);
    chk("sel_out_ch",    32'(out_ch),    32'd2);
    chk("sel_out_valid", 32'(out_valid), 32'd1);
    in_valid = 4'b1011;
    #1;
    chk("sel_idle_ch_ready", 32'(in_ready), 32'b0000);
    step();
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_data",  32'(out_data),  32'hA5);

    // round robin from reset, full throughput
    in_valid = 4'b0000;
    do_reset();
    mode     = 1'b1;
    in_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    in_valid = 4'b1111;
    #1;
    chk("rr_first_ready", 32'(in_ready), 32'b0001);
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("rr_ch%0d", i),    32'(out_ch),    32'(i % 4));
      chk($sformatf("rr_valid%0d", i), 32'(out_valid), 32'd1);
      chk($sformatf("rr_data%0d", i),  32'(out_data),  32'(8'h10 + (i % 4)));
    end

    // backpressure: rr_ptr=3, so ch0 takes 0x3C next
    in_data = {8'h13, 8'h12, 8'h11, 8'h3C};
    step();
    chk("bp_load_data", 32'(out_data), 32'h3C);
    chk("bp_load_ch",   32'(out_ch),   32'd0);
    out_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        mode = 1'b0;
        sel  = 2'd2;
      end
      chk($sformatf("bp_in_ready%0d", i), 32'(in_ready), 32'd0);
      step();
      chk($sformatf("bp_data%0d", i),  32'(out_data),  32'h3C);
      chk($sformatf("bp_ch%0d", i),    32'(out_ch),    32'd0);
      chk($sformatf("bp_valid%0d", i), 32'(out_valid), 32'd1);
    end
    mode      = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'b0010);
    step();
    chk("bp_next_ch",   32'(out_ch),   32'd1);
    chk("bp_next_data", 32'(out_data), 32'h11);

    // wrap: move rr_ptr to 0, then 1001 grants ch3 then ch0
    in_valid = 4'b0001;
    step();
    chk("wrap_setup_ch", 32'(out_ch), 32'd0);
    in_valid = 4'b1001;
    #1;
    chk("wrap_ready3", 32'(in_ready), 32'b1000);
    step();
    chk("wrap_ch3", 32'(out_ch), 32'd3);
    #1;
    chk("wrap_ready0", 32'(in_ready), 32'b0001);
    step();
    chk("wrap_ch0", 32'(out_ch), 32'd0);
    in_valid = 4'b0000;
    step();
    chk("wrap_drain_valid", 32'(out_valid), 32'd0);

    // reset during a stall
    in_valid = 4'b0100;
    step();
    chk("mid_load_ch", 32'(out_ch), 32'd2);
    out_ready = 1'b0;
    in_valid  = 4'b0000;
    step();
    chk("mid_held_valid", 32'(out_valid), 32'd1);
    in_valid = 4'b1111;
    rst_n    = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ch",    32'(out_ch),    32'd0);
    chk("mid_rst_ready", 32'(in_ready),  32'd0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("post_rst_ready", 32'(in_ready), 32'b0001);
    step();
    chk("post_rst_ch", 32'(out_ch), 32'd0);

`ifdef MUX_STATS_EN
    in_valid = 4'b0000;
    do_reset();
    mode     = 1'b0;
    sel      = 2'd1;
    in_valid = 4'b0010;
    for (int i = 0; i < 20; i++) step();
    in_valid = 4'b0000;
    step();
    chk("stat_ch0", 32'(stat_cnt[0*CNT_W +: CNT_W]), 32'd0);
    chk("stat_ch1", 32'(stat_cnt[1*CNT_W +: CNT_W]), 32'd15);
    chk("stat_ch2", 32'(stat_cnt[2*CNT_W +: CNT_W]), 32'd0);
    chk("stat_ch3", 32'(stat_cnt[3*CNT_W +: CNT_W]), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
